// File: rtl/priority_encoder_sync_if.sv
// Switch-encoder bus.
//   SW     : raw asynchronous switch lines, bit 0 = highest priority
//   CLR    : synchronous clear of a latched result
//   CODE   : index of lowest set debounced line (0 when none)
//   VALID  : at least one debounced line set, or a latched hit held
//   MULTI  : more than one debounced line set at encode/capture time
//   CHANGE : one-cycle pulse when {VALID,CODE} takes a new value
// master = switch/lab side, slave = encoder.
interface priority_encoder_sync_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] SW;
  logic         CLR;
  logic [W-1:0] CODE;
  logic         VALID;
  logic         MULTI;
  logic         CHANGE;

  modport master (output SW, CLR, input  CODE, VALID, MULTI, CHANGE);
  modport slave  (input  SW, CLR, output CODE, VALID, MULTI, CHANGE);
endinterface

// File: rtl/priority_encoder_sync.sv
// Clocked priority encoder for board switches.
// Each switch line is synchronised (2 flops) and debounced, then the
// lowest-index debounced line is encoded to a binary code with valid,
// multi-hit and change flags. LATCH=1 holds the first hit until CLR.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : priority_encoder_sync_if slave (SW/CLR in, CODE/VALID/MULTI/CHANGE out)
// SW edge to registered outputs: 2 + DEBOUNCE_CYCLES + 1 cycles.

// Per-line synchroniser + debounce filter.
//   i_sw  : raw switch line
//   o_deb : debounced level
module priority_encoder_sync_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_sw,
  output logic o_deb
);
  // One extra bit so the counter cannot wrap before reaching D-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic          r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // D consecutive mismatching cycles seen: accept the new level.
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb = r_deb;
endmodule

module priority_encoder_sync #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LATCH           = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  priority_encoder_sync_if.slave bus
);
  localparam int W = $clog2(N);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [N-1:0] w_deb;
  logic [W-1:0] w_enc_code;
  logic         w_enc_valid, w_enc_multi;

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_code, w_code_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_multi, w_multi_nxt;
  logic         r_change, w_change_nxt;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    priority_encoder_sync_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .CLK  (CLK),
      .RST_N(RST_N),
      .i_sw (bus.SW[gi]),
      .o_deb(w_deb[gi])
    );
  end

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    w_enc_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_deb[i]) w_enc_code = W'(i);
    end
  end

  assign w_enc_valid = |w_deb;
  // Clearing the lowest set bit leaves something only if >1 bit was set.
  assign w_enc_multi = (w_deb & (w_deb - N'(1))) != '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_multi  <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_valid  <= w_valid_nxt;
      r_multi  <= w_multi_nxt;
      r_change <= w_change_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_multi_nxt = r_multi;
    if (LATCH == 0) begin
      w_state_nxt = S_IDLE;
      w_code_nxt  = w_enc_code;
      w_valid_nxt = w_enc_valid;
      w_multi_nxt = w_enc_multi;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_code_nxt  = w_enc_code;
          w_valid_nxt = w_enc_valid;
          w_multi_nxt = w_enc_multi;
          if (w_enc_valid) w_state_nxt = S_HELD;
        end
        S_HELD: begin
          // Clear wins even if lines are still active; IDLE recaptures next cycle.
          if (bus.CLR) begin
            w_state_nxt = S_IDLE;
            w_code_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_multi_nxt = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // MULTI alone changing does not count as a change.
    w_change_nxt = {w_valid_nxt, w_code_nxt} != {r_valid, r_code};
  end

  assign bus.CODE   = r_code;
  assign bus.VALID  = r_valid;
  assign bus.MULTI  = r_multi;
  assign bus.CHANGE = r_change;
endmodule

// File: tb/tb_priority_encoder_sync.sv
// Bench for priority_encoder_sync: three instances (8-line live, 8-line
// latched, 16-line live) sharing clock/reset, compared each cycle against
// an ideal model: a line's debounced level flips once the synchronised
// input has shown the opposite level for D consecutive cycles.
module tb_priority_encoder_sync;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        clr = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  priority_encoder_sync_if #(.N(8))  ifa ();
  priority_encoder_sync_if #(.N(8))  ifb ();
  priority_encoder_sync_if #(.N(16)) ifc ();

  assign ifa.SW  = sw[7:0];
  assign ifb.SW  = sw[7:0];
  assign ifc.SW  = sw;
  assign ifa.CLR = clr;
  assign ifb.CLR = clr;
  assign ifc.CLR = clr;

  priority_encoder_sync #(.N(8),  .DEBOUNCE_CYCLES(TD), .LATCH(0)) dut_a (.CLK(clk), .RST_N(rst_n), .bus(ifa));
  priority_encoder_sync #(.N(8),  .DEBOUNCE_CYCLES(TD), .LATCH(1)) dut_b (.CLK(clk), .RST_N(rst_n), .bus(ifb));
  priority_encoder_sync #(.N(16), .DEBOUNCE_CYCLES(TD), .LATCH(0)) dut_c (.CLK(clk), .RST_N(rst_n), .bus(ifc));

  // Reference model state, index 0..2 = A, B, C.
  int          mN [3] = '{8, 8, 16};
  int          mL [3] = '{0, 1, 0};
  logic [15:0] m_s1 [3], m_s2 [3], m_deb [3];
  logic [15:0] m_hist [3][16];
  int          m_hcnt [3];
  logic        m_held [3];
  logic [3:0]  m_c [3];
  logic        m_v [3], m_m [3], m_chg [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = '0; m_s2[i] = '0; m_deb[i] = '0; m_hcnt[i] = 0;
      m_held[i] = 1'b0; m_c[i] = '0; m_v[i] = 1'b0; m_m[i] = 1'b0; m_chg[i] = 1'b0;
      for (int k = 0; k < 16; k++) m_hist[i][k] = '0;
    end
  endtask

  task automatic model_step();
    logic [15:0] mask, deb_old;
    int          ec;
    logic [3:0]  nc;
    logic        nv, nm, all_opp;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        model_reset();
        return;
      end
      mask    = (mN[i] == 16) ? 16'hFFFF : 16'h00FF;
      deb_old = m_deb[i];
      ec = 0;
      for (int b = mN[i] - 1; b >= 0; b--) if (deb_old[b]) ec = b;
      nc = m_c[i]; nv = m_v[i]; nm = m_m[i];
      if (mL[i] == 0 || !m_held[i]) begin
        nc = 4'(ec); nv = (deb_old != 0); nm = ($countones(deb_old) > 1);
        if (mL[i] != 0 && deb_old != 0) m_held[i] = 1'b1;
      end else if (clr) begin
        nc = '0; nv = 1'b0; nm = 1'b0; m_held[i] = 1'b0;
      end
      m_chg[i] = (nv != m_v[i]) || (nc != m_c[i]);
      m_c[i] = nc; m_v[i] = nv; m_m[i] = nm;
      for (int k = 15; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = m_s2[i];
      if (m_hcnt[i] < 16) m_hcnt[i]++;
      if (m_hcnt[i] >= TD) begin
        for (int b = 0; b < 16; b++) begin
          all_opp = 1'b1;
          for (int k = 0; k < TD; k++) if (m_hist[i][k][b] == deb_old[b]) all_opp = 1'b0;
          if (all_opp) m_deb[i][b] = ~deb_old[b];
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = sw & mask;
    end
  endtask

  task automatic cmp_all();
    chk("A.code",   32'(ifa.CODE),   32'(m_c[0]));
    chk("A.valid",  32'(ifa.VALID),  32'(m_v[0]));
    chk("A.multi",  32'(ifa.MULTI),  32'(m_m[0]));
    chk("A.change", 32'(ifa.CHANGE), 32'(m_chg[0]));
    chk("B.code",   32'(ifb.CODE),   32'(m_c[1]));
    chk("B.valid",  32'(ifb.VALID),  32'(m_v[1]));
    chk("B.multi",  32'(ifb.MULTI),  32'(m_m[1]));
    chk("B.change", 32'(ifb.CHANGE), 32'(m_chg[1]));
    chk("C.code",   32'(ifc.CODE),   32'(m_c[2]));
    chk("C.valid",  32'(ifc.VALID),  32'(m_v[2]));
    chk("C.multi",  32'(ifc.MULTI),  32'(m_m[2]));
    chk("C.change", 32'(ifc.CHANGE), 32'(m_chg[2]));
  endtask

  task automatic step(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_step();
      #1;
      cmp_all();
    end
  endtask

  initial begin
    model_reset();
    step(3);
    chk("rst.A.valid",  32'(ifa.VALID),  32'd0);
    chk("rst.B.code",   32'(ifb.CODE),   32'd0);
    chk("rst.C.change", 32'(ifc.CHANGE), 32'd0);
    rst_n = 1'b1;
    step(10);

    // Two lines set: lowest (2) wins after 7 cycles, multi-hit.
    sw = 16'h0024;
    step(6);
    chk("t1.valid_early", 32'(ifa.VALID), 32'd0);
    step(1);
    chk("t1.code",   32'(ifa.CODE),   32'd2);
    chk("t1.valid",  32'(ifa.VALID),  32'd1);
    chk("t1.multi",  32'(ifa.MULTI),  32'd1);
    chk("t1.change", 32'(ifa.CHANGE), 32'd1);
    step(1);
    chk("t1.change_off", 32'(ifa.CHANGE), 32'd0);

    // All released: back to idle after the same latency.
    sw = 16'h0000;
    step(6);
    chk("t3.valid_early", 32'(ifa.VALID), 32'd1);
    step(1);
    chk("t3.valid",  32'(ifa.VALID),  32'd0);
    chk("t3.code",   32'(ifa.CODE),   32'd0);
    chk("t3.multi",  32'(ifa.MULTI),  32'd0);
    chk("t3.change", 32'(ifa.CHANGE), 32'd1);
    step(1);
    chk("t3.change_off", 32'(ifa.CHANGE), 32'd0);
    step(4);

    // 3-cycle glitch rejected, 4-cycle pulse accepted.
    sw = 16'h0001; step(3);
    sw = 16'h0000; step(12);
    chk("t2.short_valid", 32'(ifa.VALID), 32'd0);
    sw = 16'h0001; step(4);
    sw = 16'h0000; step(3);
    chk("t2.long_valid", 32'(ifa.VALID), 32'd1);
    chk("t2.long_code",  32'(ifa.CODE),  32'd0);
    step(12);

    // Reset in the middle of a debounce count: restart from scratch.
    sw = 16'h0001; step(5);
    rst_n = 1'b0; #1;
    model_reset();
    chk("t5.async_valid", 32'(ifa.VALID), 32'd0);
    chk("t5.async_b_valid", 32'(ifb.VALID), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(6);
    chk("t5.valid_early", 32'(ifa.VALID), 32'd0);
    step(1);
    chk("t5.valid", 32'(ifa.VALID), 32'd1);

    // Latch mode: first hit held, CLR clears then recaptures.
    sw = 16'h0000; step(10);
    clr = 1'b1; step(1); clr = 1'b0; step(3);
    sw = 16'h0020; step(7);
    chk("t4.code5", 32'(ifb.CODE), 32'd5);
    sw = 16'h0022; step(8);
    chk("t4.held_code",  32'(ifb.CODE),  32'd5);
    chk("t4.held_multi", 32'(ifb.MULTI), 32'd0);
    chk("t4.live_code",  32'(ifa.CODE),  32'd1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("t4.clr_valid",  32'(ifb.VALID),  32'd0);
    chk("t4.clr_change", 32'(ifb.CHANGE), 32'd1);
    step(1);
    chk("t4.recap_code",   32'(ifb.CODE),   32'd1);
    chk("t4.recap_valid",  32'(ifb.VALID),  32'd1);
    chk("t4.recap_change", 32'(ifb.CHANGE), 32'd1);

    // 16 lines: top line alone, then line 0 added.
    sw = 16'h0000; step(10);
    sw = 16'h8000; step(7);
    chk("t6.code",  32'(ifc.CODE),  32'hF);
    chk("t6.valid", 32'(ifc.VALID), 32'd1);
    chk("t6.multi", 32'(ifc.MULTI), 32'd0);
    sw = 16'h8001; step(7);
    chk("t6.code0",  32'(ifc.CODE),  32'd0);
    chk("t6.multi1", 32'(ifc.MULTI), 32'd1);

    // Random holds of 1..8 cycles, mix of single-bit and arbitrary patterns.
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 2) == 0) sw = 16'(1 << $urandom_range(0, 15));
      else                           sw = 16'($urandom);
      for (int h = $urandom_range(1, 8); h > 0; h--) begin
        clr = ($urandom_range(0, 5) == 0);
        step(1);
      end
    end
    clr = 1'b0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
